keypad_scan_decoder: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment scan driver. It scans a 4x4 matrix keypad by driving one active-low column at a time and reading the four rows.
- It debounces across whole scan frames and emits a 4-bit hex key code with a one-cycle valid strobe.
- It sits between the board keypad pins and user logic, for example feeding hex0..hex3 of the display driver.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_frame_eval.sv | 72 +++++++
 rtl/keypad_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, frame result type,
// key map indexed by {row, col} and active-low column drive patterns.
package keypad_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } frame_res_t;

  // Entry 0 is r0c0 ('1'); rows top to bottom, columns left to right.
  localparam logic [15:0][3:0] KEY_MAP   = 64'hDF0E_C987_B654_A321;
  localparam logic [3:0][3:0]  COL_DRIVE = 16'h7BDE;

  // Hit accumulator only needs to distinguish 0, 1 and "two or more".
  function automatic logic [1:0] hit_add(input logic [1:0] acc, input logic [2:0] n);
    logic [3:0] s;
    s = {2'b00, acc} + {1'b0, n};
    return (s >= 4'd2) ? 2'd2 : s[1:0];
  endfunction

endpackage

// File: rtl/keypad_frame_eval.sv
// Row synchronizer plus per-frame hit accumulation; reports NONE/KEY/MULTI
// combinationally on the tick that samples the last column.
module keypad_frame_eval
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_row,
  input  logic       i_tick,
  input  logic [1:0] i_col_idx,
  output logic       o_frame_done,
  output frame_res_t o_frame_res,
  output logic [3:0] o_frame_pos
);

  logic [3:0] r_row_s1;
  logic [3:0] r_row_s2;
  logic [1:0] r_hit_cnt;
  logic [3:0] r_hit_pos;

  logic [3:0] w_rs;
  logic [2:0] w_col_hits;
  logic [1:0] w_row_idx;
  logic [1:0] w_cnt_next;
  logic [3:0] w_pos_next;

  assign w_rs       = ~r_row_s2;
  assign w_col_hits = 3'(w_rs[0]) + 3'(w_rs[1]) + 3'(w_rs[2]) + 3'(w_rs[3]);
  assign w_cnt_next = hit_add(r_hit_cnt, w_col_hits);

  always_comb begin
    w_row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (w_rs[r]) w_row_idx = 2'(r);
    end
  end

  // Position is only meaningful when exactly one hit occurs in the frame.
  assign w_pos_next = (r_hit_cnt == 2'd0 && w_col_hits != 3'd0) ? {w_row_idx, i_col_idx}
                                                                  : r_hit_pos;

  assign o_frame_done = i_tick && (i_col_idx == 2'd3);
  assign o_frame_pos  = w_pos_next;

  always_comb begin
    o_frame_res = RES_MULTI;
    if (w_cnt_next == 2'd0)      o_frame_res = RES_NONE;
    else if (w_cnt_next == 2'd1) o_frame_res = RES_KEY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_hit_cnt <= 2'd0;
      r_hit_pos <= 4'd0;
    end else begin
      r_row_s1 <= i_row;
      r_row_s2 <= r_row_s1;
      if (i_tick) begin
        if (i_col_idx == 2'd3) begin
          r_hit_cnt <= 2'd0;
          r_hit_pos <= 4'd0;
        end else begin
          r_hit_cnt <= w_cnt_next;
          r_hit_pos <= w_pos_next;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner: column prescaler/drive and frame-level debounce FSM that
// emits a hex key code with a one-clock valid strobe and a held flag.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_N     = 16,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DEB_L = 4'(DEB_FRAMES);

  logic [SCAN_N-1:0] r_presc;
  logic [1:0]        r_col_idx;
  logic [3:0]        r_col;
  logic [1:0]        r_state;
  logic [3:0]        r_cand;
  logic [3:0]        r_cnt;
  logic [3:0]        r_code;
  logic              r_valid;
  logic              r_held;

  logic       w_tick;
  logic       w_frame_done;
  frame_res_t w_frame_res;
  logic [3:0] w_frame_pos;
  logic       w_is_key;
  logic       w_is_cand;

  assign w_tick = &r_presc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_col_idx <= 2'd0;
      r_col     <= COL_DRIVE[0];
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= COL_DRIVE[r_col_idx + 2'd1];
      end
    end
  end

  keypad_frame_eval u_frame_eval (
    .clk          (clk),
    .reset        (reset),
    .i_row        (row),
    .i_tick       (w_tick),
    .i_col_idx    (r_col_idx),
    .o_frame_done (w_frame_done),
    .o_frame_res  (w_frame_res),
    .o_frame_pos  (w_frame_pos)
  );

  // r_cand is the candidate while debouncing and the held key afterwards.
  assign w_is_key  = (w_frame_res == RES_KEY);
  assign w_is_cand = w_is_key && (w_frame_pos == r_cand);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= 4'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_frame_done) begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_key) begin
              r_cand <= w_frame_pos;
              r_cnt  <= 4'd1;
              if (DEB_L == 4'd1) begin
                r_code  <= KEY_MAP[w_frame_pos];
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_state <= ST_PRESSED;
              end else begin
                r_state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (w_is_cand) begin
              if (r_cnt + 4'd1 == DEB_L) begin
                r_code  <= KEY_MAP[w_frame_pos];
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_state <= ST_PRESSED;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else if (w_is_key) begin
              r_cand <= w_frame_pos;
              r_cnt  <= 4'd1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (!w_is_cand) begin
              r_cnt <= 4'd1;
              if (DEB_L == 4'd1) begin
                r_held  <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (w_is_cand) begin
              r_cnt   <= 4'd0;
              r_state <= ST_PRESSED;
            end else if (r_cnt + 4'd1 == DEB_L) begin
              r_held  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Self-checking bench: keypad matrix model driving rows from col, scoreboard of
// expected key codes popped on every key_valid pulse.
module tb_keypad_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_cols[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  keypad_scan_decoder #(.SCAN_N(2), .DEB_FRAMES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset && key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_key_valid got code=%h required no pulse", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code || prev_valid) begin
          failures++;
          $display("FAIL key_pulse got code=%h prev_valid=%b required code=%h single pulse",
                   key_code, prev_valid, exp_code);
        end
      end
    end
    prev_valid = key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pressed = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got col=%b code=%h valid=%b held=%b required 1110 0 0 0",
               col, key_code, key_valid, key_held);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_scan;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (col !== exp_cols[(k/4)%4] || key_code !== 4'h0 || key_held !== 1'b0) begin
        failures++;
        $display("FAIL idle_scan cyc=%0d got col=%b code=%h held=%b required col=%b code=0 held=0",
                 k, col, key_code, key_held, exp_cols[(k/4)%4]);
      end
    end
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL %s_release got held=%b required 0 within 80 cycles", name, key_held);
    end
    wait_cycles(20);
  endtask

  task automatic test_key6;
    int n;
    pressed = 16'h0;
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_pulse(70, n);
    checks++;
    if (exp_q.size() != 0 || n < 32 || n > 66) begin
      failures++;
      $display("FAIL key6_latency got cycles=%0d pending=%0d required 32..66 and pulse",
               n, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (key_code !== 4'h6 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL key6_accept got code=%h held=%b required 6 1", key_code, key_held);
    end
    for (int f = 0; f < 3; f++) begin
      wait_cycles(16);
      checks++;
      if (key_held !== 1'b1) begin
        failures++;
        $display("FAIL key6_hold frame=%0d got held=%b required 1", f, key_held);
      end
    end
    pressed = 16'h0;
    wait_cycles(30);
    checks++;
    if (key_held !== 1'b1) begin
      failures++;
      $display("FAIL key6_early_release got held=%b required 1", key_held);
    end
    wait_release("key6");
  endtask

  task automatic test_short_press;
    int n;
    pressed = 16'h0;
    pressed[12] = 1'b1;
    wait_cycles(32);
    pressed = 16'h0;
    wait_cycles(64);
    checks++;
    if (key_code !== 4'h6 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL short_press got code=%h held=%b required 6 0", key_code, key_held);
    end
    pressed[3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_cycles(80);
    pressed = 16'h0;
    wait_pulse(70, n);
    checks++;
    if (exp_q.size() != 0 || key_code !== 4'hA) begin
      failures++;
      $display("FAIL keyA_accept got code=%h pending=%0d required A and pulse",
               key_code, exp_q.size());
      exp_q.delete();
    end
    wait_release("keyA");
  endtask

  task automatic test_multi;
    int n;
    pressed = 16'h0;
    pressed[0] = 1'b1;
    pressed[9] = 1'b1;
    wait_cycles(80);
    checks++;
    if (key_held !== 1'b0 || key_code !== 4'hA) begin
      failures++;
      $display("FAIL multi_reject got code=%h held=%b required A 0", key_code, key_held);
    end
    pressed[9] = 1'b0;
    exp_q.push_back(4'h1);
    wait_pulse(70, n);
    checks++;
    if (exp_q.size() != 0 || key_code !== 4'h1 || n < 32) begin
      failures++;
      $display("FAIL multi_to_key1 got code=%h cycles=%0d pending=%0d required 1 within 32..70",
               key_code, n, exp_q.size());
      exp_q.delete();
    end
    pressed = 16'h0;
    wait_release("key1");
  endtask

  task automatic test_back_to_back;
    int n;
    logic seen_drop;
    pressed = 16'h0;
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_pulse(70, n);
    checks++;
    if (exp_q.size() != 0 || key_code !== 4'h5) begin
      failures++;
      $display("FAIL key5_accept got code=%h pending=%0d required 5", key_code, exp_q.size());
      exp_q.delete();
    end
    pressed[10] = 1'b1;
    wait_cycles(30);
    checks++;
    if (key_held !== 1'b1 || key_code !== 4'h5) begin
      failures++;
      $display("FAIL overlap_hold got code=%h held=%b required 5 1", key_code, key_held);
    end
    pressed[5] = 1'b0;
    exp_q.push_back(4'h9);
    seen_drop = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 140) begin
      @(negedge clk);
      n++;
      if (key_held === 1'b0) seen_drop = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0 || !seen_drop || key_code !== 4'h9) begin
      failures++;
      $display("FAIL key9_after_5 got code=%h dropped=%b pending=%0d required 9 after release",
               key_code, seen_drop, exp_q.size());
      exp_q.delete();
    end
    pressed = 16'h0;
    wait_release("key9");
  endtask

  task automatic test_reset_mid;
    int n;
    pressed = 16'h0;
    pressed[9] = 1'b1;
    exp_q.push_back(4'h8);
    wait_pulse(70, n);
    checks++;
    if (exp_q.size() != 0 || key_code !== 4'h8 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL key8_accept got code=%h held=%b required 8 1", key_code, key_held);
      exp_q.delete();
    end
    wait_cycles(5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got col=%b code=%h valid=%b held=%b required 1110 0 0 0",
               col, key_code, key_valid, key_held);
    end
    exp_q.push_back(4'h8);
    wait_pulse(80, n);
    checks++;
    if (exp_q.size() != 0 || n < 44 || n > 52 || key_code !== 4'h8) begin
      failures++;
      $display("FAIL key8_redebounce got code=%h cycles=%0d pending=%0d required 8 at 44..52",
               key_code, n, exp_q.size());
      exp_q.delete();
    end
    pressed = 16'h0;
    wait_release("key8");
  endtask

  initial begin
    reset = 1'b1;
    pressed = 16'h0;
    test_reset();
    test_idle_scan();
    test_key6();
    test_short_press();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
